// File: rtl/seq_signed_or_unsigned_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_signed_or_unsigned_mul
// Description : Iterative n x n shift-add multiplier with a per-operation
//               signed/unsigned select and valid/ready handshakes on both the
//               operand and result sides. One product bit-step per clock,
//               2n-bit result after n BUSY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_or_unsigned_mul #(
   parameter int n = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [n-1:0]     a,
   input  logic [n-1:0]     b,
   input  logic             sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*n-1:0]   res
);

   localparam int c_cnt_w = $clog2(n) + 1;
   localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(n - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic                 r_sign;
   logic                 r_neg;
   logic [2*n-1:0]       r_mcand;   // multiplicand, shifted left each step
   logic [n-1:0]         r_mplier;  // multiplier, shifted right each step
   logic [2*n-1:0]       r_acc;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2*n-1:0]       r_res;

   logic [n-1:0]         w_a_mag;
   logic [n-1:0]         w_b_mag;
   logic [2*n-1:0]       w_addend;
   logic [2*n-1:0]       w_acc_sum;
   logic [2*n-1:0]       w_res_final;

   // Magnitudes of the incoming operands; negating -2^(n-1) yields 2^(n-1),
   // which is still representable as an n-bit unsigned value.
   assign w_a_mag = (sign && a[n-1]) ? (~a + {{(n-1){1'b0}}, 1'b1}) : a;
   assign w_b_mag = (sign && b[n-1]) ? (~b + {{(n-1){1'b0}}, 1'b1}) : b;

   // Partial-product accumulate for the current step.
   assign w_addend  = r_mplier[0] ? r_mcand : '0;
   assign w_acc_sum = r_acc + w_addend;

   // Sign correction of the finished magnitude product. r_neg already implies
   // r_sign; the extra gate keeps unsigned operations off the negation path.
   assign w_res_final = (r_sign && r_neg) ? (~w_acc_sum + {{(2*n-1){1'b0}}, 1'b1})
                                          : w_acc_sum;

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign res       = r_res;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: accept in IDLE, n steps in BUSY, hold in DONE until taken.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt == c_last_step) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, shift-add steps and result write on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign   <= 1'b0;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_res    <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_sign   <= sign;
                  r_neg    <= sign & (a[n-1] ^ b[n-1]);
                  r_mcand  <= {{n{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            ST_BUSY: begin
               r_acc    <= w_acc_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == c_last_step) begin
                  r_res <= w_res_final;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_or_unsigned_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_signed_or_unsigned_mul
// Description : Self-checking bench for seq_signed_or_unsigned_mul at n=4:
//               corner table, exhaustive sweep, random ops, backpressure,
//               reset mid-operation and continuous-valid handshake stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_signed_or_unsigned_mul;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            sign = 1'b0;
   logic            out_ready = 1'b1;
   logic [N-1:0]    a = '0;
   logic [N-1:0]    b = '0;
   logic            in_ready;
   logic            out_valid;
   logic [2*N-1:0]  res;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       s;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[8];

   seq_signed_or_unsigned_mul #(.n(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sign      (sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res)
   );

   always #5 clk = ~clk;

   // Reference: interpret operands per mode, multiply as integers, keep 2n bits.
   function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y,
                                          input logic s);
      int xi;
      int yi;
      xi = int'(x);
      yi = int'(y);
      if (s && x[3]) xi -= 16;
      if (s && y[3]) yi -= 16;
      return 8'(xi * yi);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   // Present one operation in IDLE, scramble inputs after the accept edge and
   // count edges until out_valid is seen (bounded).
   task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                        output int lat);
      @(negedge clk);
      a = ta; b = tb_v; sign = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 4'($urandom); b = 4'($urandom); sign = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Full operation with out_ready=1: check result and latency, then retire.
   task automatic op_check(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                           input logic [7:0] exp, input string nm);
      int lat;
      issue(ta, tb_v, ts, lat);
      chk({nm, " res"}, 32'(res), 32'(exp));
      chk({nm, " latency"}, 32'(lat), 32'd4);
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] ha[40];
      logic [3:0] hb[40];
      logic       hs[40];
      logic [3:0] ra, rb;
      logic       rs;
      int         lat;

      vecs[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};
      vecs[1] = '{4'h8, 4'h8, 1'b1, 8'h40};
      vecs[2] = '{4'h8, 4'h7, 1'b1, 8'hC8};
      vecs[3] = '{4'hF, 4'hF, 1'b1, 8'h01};
      vecs[4] = '{4'h7, 4'h7, 1'b1, 8'h31};
      vecs[5] = '{4'h8, 4'h1, 1'b0, 8'h08};
      vecs[6] = '{4'h8, 4'h1, 1'b1, 8'hF8};
      vecs[7] = '{4'h0, 4'h9, 1'b1, 8'h00};

      // Reset state
      #2;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset res", 32'(res), 32'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // Corner table
      for (int i = 0; i < 8; i++) begin
         op_check(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, "corner");
      end

      // Exhaustive sweep, both modes
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
               op_check(4'(i), 4'(j), 1'(s), ref_mul(4'(i), 4'(j), 1'(s)), "sweep");
            end
         end
      end

      // Random operations
      for (int k = 0; k < 40; k++) begin
         ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
         op_check(ra, rb, rs, ref_mul(ra, rb, rs), "random");
      end

      // Backpressure: hold DONE for 10 cycles while inputs toggle
      out_ready = 1'b0;
      issue(4'd13, 4'd11, 1'b0, lat);
      chk("bp latency", 32'(lat), 32'd4);
      chk("bp res", 32'(res), 32'h8F);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         a = 4'($urandom); b = 4'($urandom); sign = 1'($urandom); in_valid = 1'b1;
         @(posedge clk); #1;
         chk("bp out_valid", 32'(out_valid), 32'd1);
         chk("bp res hold", 32'(res), 32'h8F);
         chk("bp in_ready", 32'(in_ready), 32'd0);
      end
      // Release with in_valid still high: DONE must go to IDLE, not accept
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("release in_ready", 32'(in_ready), 32'd1);
      chk("release out_valid", 32'(out_valid), 32'd0);
      chk("release res", 32'(res), 32'h8F);

      // Reset two cycles into BUSY
      @(negedge clk);
      a = 4'd9; b = 4'd6; sign = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst res", 32'(res), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      op_check(4'd3, 4'd5, 1'b0, 8'd15, "post-reset");

      // Continuous in_valid with a changing operand stream: accepts every 6 edges
      for (int c = 0; c < 36; c++) begin
         @(negedge clk);
         chk("stream in_ready", 32'(in_ready), 32'((c % 6) == 0));
         chk("stream out_valid", 32'(out_valid), 32'((c % 6) == 5));
         if ((c % 6) == 5) begin
            chk("stream res", 32'(res), 32'(ref_mul(ha[c-5], hb[c-5], hs[c-5])));
         end
         ha[c] = 4'($urandom);
         hb[c] = 4'($urandom);
         hs[c] = 1'((c / 6) % 2);
         a = ha[c]; b = hb[c]; sign = hs[c]; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
